// File: rtl/weight_sram_ctrl.sv
// weight_sram_ctrl: shares the weight SRAM read port between the conv engine
// (port 0) and the FC engine (port 1) with round-robin arbitration over whole
// bursts, streams one read address per cycle, returns tagged read data and
// forwards loader writes onto the SRAM write port concurrently with reads.
//
// Optional feature macro: WSRAM_RANGE_CHK_EN
//   defined   - bursts with addr+len > DEPTH and writes with ld_addr >= DEPTH
//               are rejected with a one-cycle err pulse.
//   undefined - no range check, err is tied low.
module weight_sram_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 100,
  parameter int DEPTH  = 20000,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rd_valid,
  output logic              rd_last,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_raddr,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } req_t;

  state_t            state;
  logic              rr_ptr;     // port preferred when both request
  logic              cur_port;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic [1:0]        vld_pipe;   // read-return valid, one cycle behind address
  logic              last_pipe;

  logic [1:0]        grant;
  logic              gnt_port;
  req_t              req_sel;
  logic [LEN_W-1:0]  len_eff;
  logic              range_bad;
  logic              ld_bad;
  logic              read_issue;
  logic              wr_issue;

  // Arbitration: a single requester always wins; on contention rr_ptr decides.
  always_comb begin
    grant    = '0;
    gnt_port = 1'b0;
    if (state == IDLE && !rst && req_valid != 2'b00) begin
      gnt_port        = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
      grant[gnt_port] = 1'b1;
    end
  end

  // Selected request fields, zero length treated as a single word.
  always_comb begin
    req_sel = gnt_port ? '{addr: req_addr1, len: req_len1}
                       : '{addr: req_addr0, len: req_len0};
    len_eff = (req_sel.len == '0) ? LEN_W'(1) : req_sel.len;
  end

`ifdef WSRAM_RANGE_CHK_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  logic [SUM_W-1:0] end_sum;

  // Burst must end at or before DEPTH; writes must land below DEPTH.
  always_comb begin
    end_sum   = SUM_W'(req_sel.addr) + SUM_W'(len_eff);
    range_bad = (end_sum > DEPTH_S);
    ld_bad    = ld_valid && (SUM_W'(ld_addr) >= DEPTH_S);
  end
`else
  // No range check: every request and write goes through as given.
  always_comb begin
    range_bad = 1'b0;
    ld_bad    = 1'b0;
  end
`endif

  // SRAM-side strobes and status outputs.
  always_comb begin
    read_issue = (state == BURST);
    wr_issue   = ld_valid && !ld_bad;
    sram_csb   = ~(read_issue | ld_valid);
    sram_wsb   = ~wr_issue;
    sram_raddr = cur_addr;
    sram_waddr = ld_addr;
    sram_wdata = ld_data;
    req_ready  = grant;
    rd_valid   = vld_pipe;
    rd_last    = last_pipe;
    rd_data    = sram_rdata;
    busy       = (state != IDLE) || (vld_pipe != 2'b00);
    err        = !rst && (((grant != 2'b00) && range_bad) || ld_bad);
  end

  // Burst FSM plus registered read-return tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cur_port  <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      vld_pipe  <= 2'b00;
      last_pipe <= 1'b0;
    end else begin
      vld_pipe  <= 2'b00;
      last_pipe <= 1'b0;
      if (read_issue) begin
        vld_pipe  <= cur_port ? 2'b10 : 2'b01;
        last_pipe <= (remaining == LEN_W'(1));
      end
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            rr_ptr <= ~gnt_port;
            // A rejected request is still handshaken but issues no reads.
            if (!range_bad) begin
              state     <= BURST;
              cur_port  <= gnt_port;
              cur_addr  <= req_sel.addr;
              remaining <= len_eff;
            end
          end
        end
        BURST: begin
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_sram_ctrl.md
# weight_sram_ctrl

Read/write controller for the 20000×100b weight SRAM. It shares the SRAM's single read port between the conv engine (port 0) and the FC engine (port 1), using round-robin arbitration over whole bursts. It streams each granted burst as one address per cycle and returns tagged read data. It also forwards loader writes onto the SRAM write port, concurrently with reads.

## Interface
Parameters:
- ADDR_W, 15, SRAM address width
- DATA_W, 100, weight word width (25 weights × 4b)
- DEPTH, 20000, valid word count (addresses 0..DEPTH-1)
- LEN_W, 15, burst-length width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  burst request per port (bit0 conv, bit1 fc)
- req_addr0 / req_addr1  in  ADDR_W  burst start address
- req_len0 / req_len1  in  LEN_W  word count; 0 is treated as 1
- req_ready  out  2  one-hot grant pulse; handshake completes when req_valid&req_ready
- rd_valid  out  2  one-hot; rd_data valid for the indicated port
- rd_last  out  1  final word of the burst, qualified by rd_valid
- rd_data  out  DATA_W  pass-through of SRAM rdata
- ld_valid  in  1  loader write strobe
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- sram_csb  out  1  SRAM chip enable, active-low
- sram_wsb  out  1  SRAM write enable, active-low
- sram_raddr / sram_waddr  out  ADDR_W  SRAM addresses
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data
- busy  out  1  state != IDLE or read data still in flight
- err  out  1  one-cycle pulse on a rejected request or write (range check only)

## Operation
FSM:
- IDLE: if any req_valid bit is set, grant one port and move to BURST.
  - Both ports requesting: grant the port not granted last (rr_ptr); rr_ptr then points to the other port.
  - A single requester is granted regardless of rr_ptr.
  - Grant cycle: req_ready pulses for the winner; the controller latches addr, len and the port id.
- BURST: drive sram_raddr = cur_addr and sram_csb = 0 each cycle; cur_addr++, remaining--.
  - After the cycle with remaining==1, return to IDLE.
  - One dead IDLE cycle always separates bursts.
- Read return, registered one cycle behind each address: rd_valid[port] and rd_last are registered. rd_data = sram_rdata, combinational.

Write path (independent of the FSM):
- When ld_valid is high: sram_wsb=0, sram_csb=0, sram_waddr=ld_addr, sram_wdata=ld_data, all in the same cycle.
- Writes are accepted in every state; there is no ready signal.
- sram_csb = ~(read_issue | ld_valid).

Write/read collision at the same address in the same cycle: the read returns the old word. The new value is visible to reads issued from the next cycle.

Address arithmetic is ADDR_W wide. With the range check compiled out, an address past DEPTH-1 continues incrementing and the read data is undefined. Wrap at 2^ADDR_W is modulo.

Reset mid-burst: next cycle state=IDLE, rr_ptr=0 (conv first), and the in-flight rd_valid is cleared. No rd_last is emitted for the aborted burst.

Reset values: req_ready=0, rd_valid=0, rd_last=0, sram_csb=1, sram_wsb=1, sram_raddr=0, busy=0, err=0. sram_waddr and sram_wdata follow the ld_* inputs.

## Timing
- Grant at cycle T (req_ready=1).
- First address at T+1.
- First rd_valid at T+2.
- Last rd_valid (with rd_last) at T+1+len.
- Earliest next grant at T+1+len; the new burst's first rd_valid follows the previous rd_last with exactly one idle cycle.
- Requesters must accept rd_data on every rd_valid; there is no backpressure.
- req_* fields must be stable while req_valid is high and not granted. The request may be withdrawn before grant.
- Write latency: the word is in the array at the end of the ld_valid cycle.

## Configuration
WSRAM_RANGE_CHK_EN:
- Defined: a granted request with addr+len > DEPTH gets a grant pulse and an err pulse in the same cycle, issues no reads, and the FSM stays in IDLE. An ld_valid with ld_addr >= DEPTH pulses err with sram_wsb held 1, and the write is dropped.
- Undefined: no check, err is tied to 0, and every request and write is issued as given.

## Test plan
- Preload mem[21..25] = 21..25 via ld, then conv requests addr=21 len=5. Required: grant at T, rd_valid[0] at T+2..T+6 with data 21..25, rd_last at T+6.
- Both ports request every cycle with len=2. Required: grants alternate conv, fc, conv (starting with conv after reset) and each burst takes 3 cycles.
- fc burst at addr=1100 len=4 with an ld write to 1101 during the cycle address 1101 is issued. Required: old value returned; a re-read returns the new value.
- rst asserted at the third beat of a len=8 burst. Required: next cycle rd_valid=0, busy=0, sram_csb=1, no rd_last; the following grant goes to conv.
- With WSRAM_RANGE_CHK_EN: request addr=19998 len=3. Required: req_ready and err pulse together with no rd_valid. An ld to address 20000 produces err and sram_wsb stays 1.
- len=0 request at addr=20. Required: a single beat returns mem[20] with rd_last=1.
